// File: rtl/pzx_sram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pzx_sram_loader
//  Purpose  : Upstream feeder for pzx_player. Bytes written by the Z80 through
//             the ZX-UNO register port are queued in a 4-deep FIFO. Each byte
//             is written to external SRAM as a timed asynchronous write cycle
//             (SETUP / PULSE / HOLD). A 21-bit pointer auto-increments after
//             every byte. The loader claims the SRAM bus only while the player
//             is not playing.
//  Ports    :
//    clk          system clock (28 MHz)
//    rst_n        synchronous active-low reset
//    zxuno_addr   selected ZX-UNO register number
//    zxuno_regrd  one-clock register read strobe
//    zxuno_regwr  one-clock register write strobe
//    din          CPU write data
//    dout         status byte (valid while oe_n = 0)
//    oe_n         low while the status register is being read
//    playing      player active; no new SRAM cycle may start while high
//    sram_req     loader owns the SRAM bus (mux select)
//    sram_addr    SRAM address
//    sram_dout    SRAM write data
//    sram_we_n    SRAM write enable, active low
//    busy         FIFO non-empty or write engine active
//  Revision : 1.0 - initial release
// ============================================================================
module pzx_sram_loader #(
  parameter logic [7:0]  REG_ADDR  = 8'hE8,
  parameter logic [7:0]  REG_DATA  = 8'hE9,
  parameter logic [7:0]  REG_STAT  = 8'hEA,
  parameter int unsigned WE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  zxuno_addr,
  input  logic        zxuno_regrd,
  input  logic        zxuno_regwr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe_n,
  input  logic        playing,
  output logic        sram_req,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_we_n,
  output logic        busy
);

  localparam logic [2:0] c_fifo_depth = 3'd4;
  localparam logic [2:0] c_pulse_last = 3'(WE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [20:0] r_ptr;
  logic [20:0] w_ptr_next;
  logic [7:0]  r_mem [0:3];
  logic [1:0]  r_wr_idx;
  logic [1:0]  r_rd_idx;
  logic [1:0]  w_rd_idx_inc;
  logic [2:0]  r_count;
  logic [2:0]  w_count_next;
  logic [2:0]  r_pulse_cnt;
  logic        r_ovf;
  logic        r_addr_err;
  logic        r_busy;
  logic        r_sram_req;
  logic        r_we_n;
  logic [20:0] r_sram_addr;
  logic [7:0]  r_sram_dout;

  logic        w_addr_wr;
  logic        w_data_wr;
  logic        w_stat_rd;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_addr_load;
  logic        w_addr_rej;

  // --------------------------------------------------------------------------
  // Register-port decode
  // --------------------------------------------------------------------------
  assign w_addr_wr = zxuno_regwr && (zxuno_addr == REG_ADDR);
  assign w_data_wr = zxuno_regwr && (zxuno_addr == REG_DATA);
  assign w_stat_rd = zxuno_regrd && (zxuno_addr == REG_STAT);

  assign w_full  = (r_count == c_fifo_depth);
  assign w_empty = (r_count == 3'd0);

  // HOLD always lasts exactly one clock, so leaving it is the same as being in it.
  assign w_pop = (r_state == ST_HOLD);

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push = w_data_wr && (!w_full || w_pop);
  assign w_drop = w_data_wr && w_full && !w_pop;

  // The pointer may only be reloaded while nothing is queued or in flight,
  // otherwise queued bytes would land at an unexpected address.
  assign w_addr_load = w_addr_wr && !r_busy;
  assign w_addr_rej  = w_addr_wr && r_busy;

  assign w_rd_idx_inc = r_rd_idx + 2'd1;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 3'd1;
      2'b01:   w_count_next = r_count - 3'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointer wraps naturally from 21'h1FFFFF to 0 through the 21-bit add.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_pop) begin
      w_ptr_next = r_ptr + 21'd1;
    end else if (w_addr_load) begin
      w_ptr_next = {r_ptr[12:0], din};
    end
  end

  // --------------------------------------------------------------------------
  // Write engine: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !playing) begin
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_PULSE;
      end
      ST_PULSE: begin
        if (r_pulse_cnt == c_pulse_last) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // The head is popped on this edge, so another byte needs count >= 2.
        if ((r_count >= 3'd2) && !playing) begin
          w_state_next = ST_SETUP;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset; the indices define validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_idx] <= din;
    end
  end

  // --------------------------------------------------------------------------
  // State, pointer, FIFO control, sticky flags and registered bus outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pulse_cnt <= 3'd0;
      r_ptr       <= 21'd0;
      r_wr_idx    <= 2'd0;
      r_rd_idx    <= 2'd0;
      r_count     <= 3'd0;
      r_ovf       <= 1'b0;
      r_addr_err  <= 1'b0;
      r_busy      <= 1'b0;
      r_sram_req  <= 1'b0;
      r_we_n      <= 1'b1;
      r_sram_addr <= 21'd0;
      r_sram_dout <= 8'd0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == ST_PULSE) && (w_state_next == ST_PULSE)) begin
        r_pulse_cnt <= r_pulse_cnt + 3'd1;
      end else begin
        r_pulse_cnt <= 3'd0;
      end

      if (w_push) begin
        r_wr_idx <= r_wr_idx + 2'd1;
      end
      if (w_pop) begin
        r_rd_idx <= w_rd_idx_inc;
      end
      r_count <= w_count_next;
      r_ptr   <= w_ptr_next;

      // Status read clears the sticky flags, but a new event on the same edge wins.
      r_ovf      <= w_drop     || (r_ovf      && !w_stat_rd);
      r_addr_err <= w_addr_rej || (r_addr_err && !w_stat_rd);

      // Outputs are decoded from the next state so they change on the same
      // edge as the state itself.
      r_sram_req <= (w_state_next != ST_IDLE);
      r_we_n     <= (w_state_next != ST_PULSE);
      r_busy     <= (w_count_next != 3'd0) || (w_state_next != ST_IDLE);

      // Address and data are latched once on entry to SETUP and then held
      // through PULSE and HOLD. Coming from HOLD, the head is being popped,
      // so the byte behind it is the one to present.
      if (w_state_next == ST_SETUP) begin
        r_sram_addr <= w_ptr_next;
        r_sram_dout <= w_pop ? r_mem[w_rd_idx_inc] : r_mem[r_rd_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dout      = {w_full, ~r_busy, r_ovf, r_addr_err, playing, r_count};
  assign oe_n      = ~w_stat_rd;
  assign sram_req  = r_sram_req;
  assign sram_addr = r_sram_addr;
  assign sram_dout = r_sram_dout;
  assign sram_we_n = r_we_n;
  assign busy      = r_busy;

endmodule
`default_nettype wire
